cic_decimator: RTL and testbench

//  N-stage CIC (Hogenauer) decimator turning the 1-bit sigma-delta modulator bitstream into

---
 rtl/sdm_pkg.sv | 16 +
 rtl/cic_comb_stage.sv | 44 ++++
 rtl/cic_decimator.sv | 130 +++++++++++++
 tb/tb_cic_decimator.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
// rtl/sdm_pkg.sv - shared sigma-delta chain constants and CIC width helper
package sdm_pkg;

    // Default PCM sample width used between the CIC and the FIR stage
    localparam int PCM_DATA_WIDTH = 16;

    // Modulator bit mapping as 2-bit signed values
    localparam logic signed [1:0] BIT_POS = 2'sb01;
    localparam logic signed [1:0] BIT_NEG = 2'sb11;

    // Register growth of an ORDER-stage, rate 2**log2_dec CIC fed with +/-1 samples
    function automatic int CIC_ACC_WIDTH(input int order, input int log2_dec);
        return 2 + order * log2_dec;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// rtl/cic_comb_stage.sv - one strobed comb stage, differential delay 1
module cic_comb_stage #(
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe_in,
    input  logic [WIDTH-1:0] x_in,
    output logic             strobe_out,
    output logic [WIDTH-1:0] y_out
);

    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             strobe_q, strobe_d;

    // Difference against the previous decimated input, only when our strobe arrives
    always_comb begin
        y_d      = y_q;
        prev_d   = prev_q;
        strobe_d = strobe_in;
        if (strobe_in) begin
            y_d    = x_in - prev_q;
            prev_d = x_in;
        end
    end

    // State registers; the strobe moves on one stage per clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q      <= '0;
            prev_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            y_q      <= y_d;
            prev_q   <= prev_d;
            strobe_q <= strobe_d;
        end
    end

    assign y_out      = y_q;
    assign strobe_out = strobe_q;

endmodule

// File: rtl/cic_decimator.sv
// rtl/cic_decimator.sv - ORDER-stage CIC decimator for the 1-bit modulator stream
module cic_decimator
    import sdm_pkg::*;
#(
    parameter int ORDER      = 3,
    parameter int DECIMATION = 16,
    parameter int LOG2_DEC   = 4,
    parameter int DATA_WIDTH = PCM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic                  bit_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int ACC_WIDTH = CIC_ACC_WIDTH(ORDER, LOG2_DEC);
    localparam logic [LOG2_DEC-1:0] CNT_LAST = LOG2_DEC'(DECIMATION - 1);

    logic signed [1:0]     in_bit;
    logic [ACC_WIDTH-1:0]  in_ext;

    logic [ACC_WIDTH-1:0]  integ_q [ORDER];
    logic [ACC_WIDTH-1:0]  integ_d [ORDER];
    logic [LOG2_DEC-1:0]   cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0]  cap_q, cap_d;
    logic                  strobe_q, strobe_d;

    logic [ORDER:0][ACC_WIDTH-1:0] comb_x;
    logic [ORDER:0]                comb_s;

    logic [DATA_WIDTH-1:0] mapped;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;

    assign in_bit = bit_in ? BIT_POS : BIT_NEG;
    assign in_ext = {{(ACC_WIDTH-2){in_bit[1]}}, in_bit};

    // Integrator chain, frame counter and decimation capture, all gated by valid_in
    always_comb begin
        for (int k = 0; k < ORDER; k++) begin
            integ_d[k] = integ_q[k];
        end
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        strobe_d = 1'b0;
        if (valid_in) begin
            // Each stage adds the previous stage's registered value: one stage per input
            integ_d[0] = integ_q[0] + in_ext;
            for (int k = 1; k < ORDER; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            cnt_d = cnt_q + LOG2_DEC'(1);
            if (cnt_q == CNT_LAST) begin
                cap_d    = integ_d[ORDER-1];
                strobe_d = 1'b1;
            end
        end
    end

    // Integrator-side registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= '0;
            end
            cnt_q    <= '0;
            cap_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            for (int k = 0; k < ORDER; k++) begin
                integ_q[k] <= integ_d[k];
            end
            cnt_q    <= cnt_d;
            cap_q    <= cap_d;
            strobe_q <= strobe_d;
        end
    end

    assign comb_x[0] = cap_q;
    assign comb_s[0] = strobe_q;

    genvar g;
    generate
        for (g = 0; g < ORDER; g++) begin : g_comb
            cic_comb_stage #(
                .WIDTH(ACC_WIDTH)
            ) u_comb (
                .clk       (clk),
                .rst       (rst),
                .strobe_in (comb_s[g]),
                .x_in      (comb_x[g]),
                .strobe_out(comb_s[g+1]),
                .y_out     (comb_x[g+1])
            );
        end

        // Align the comb result to the PCM word: MSB of the accumulator at the MSB of data_out
        if (ACC_WIDTH <= DATA_WIDTH) begin : g_map_shift
            assign mapped = DATA_WIDTH'(comb_x[ORDER]) << (DATA_WIDTH - ACC_WIDTH);
        end else begin : g_map_trunc
            assign mapped = comb_x[ORDER][ACC_WIDTH-1 -: DATA_WIDTH];
        end
    endgenerate

    // Output register loads on the last comb strobe and holds otherwise
    always_comb begin
        data_d  = data_q;
        valid_d = comb_s[ORDER];
        if (comb_s[ORDER]) begin
            data_d = mapped;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// tb/tb_cic_decimator.sv - self-checking bench for cic_decimator against a FIR-form CIC model
module tb_cic_decimator;

    localparam int ORDER   = 3;
    localparam int DEC     = 16;
    localparam int LOG2    = 4;
    localparam int DW      = 16;
    localparam int ACC_W   = 2 + ORDER * LOG2;
    localparam int HLEN    = ORDER * (DEC - 1) + 1;

    logic          clk;
    logic          rst;
    logic          valid_in;
    logic          bit_in;
    logic          valid_out;
    logic [DW-1:0] data_out;

    cic_decimator #(
        .ORDER(ORDER), .DECIMATION(DEC), .LOG2_DEC(LOG2), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .bit_in(bit_in),
        .valid_out(valid_out), .data_out(data_out)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            h [HLEN];
    int            xs [$];
    exp_t          exp_q [$];
    logic [DW-1:0] obs_seq [$];
    logic [DW-1:0] t1_seq [$];
    logic [DW-1:0] last_out = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    // Impulse response of (sum_{i<DEC} z^-i)^ORDER
    initial begin
        int tmp [HLEN];
        int len;
        for (int i = 0; i < HLEN; i++) h[i] = 0;
        h[0] = 1;
        len  = 1;
        repeat (ORDER) begin
            for (int i = 0; i < HLEN; i++) tmp[i] = 0;
            for (int i = 0; i < len; i++)
                for (int j = 0; j < DEC; j++)
                    tmp[i+j] += h[i];
            len += DEC - 1;
            h = tmp;
        end
    end

    // Expected output for the decimating input just appended to xs
    function automatic logic [DW-1:0] model_out();
        int n, idx, y, acc;
        n = xs.size() - 1;
        y = 0;
        for (int j = 0; j < HLEN; j++) begin
            idx = n - (ORDER - 1) - j;
            if (idx >= 0) y += h[j] * xs[idx];
        end
        acc = y & ((1 << ACC_W) - 1);
        if (ACC_W <= DW) return DW'(acc << (DW - ACC_W));
        else             return DW'(acc >> (ACC_W - DW));
    endfunction

    // Input-side model: record accepted samples and schedule expected pulses
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            xs.delete();
        end else if (valid_in) begin
            xs.push_back(bit_in ? 1 : -1);
            if (xs.size() % DEC == 0)
                exp_q.push_back('{model_out(), cyc + ORDER + 1});
        end
    end

    // Output monitor on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            last_out = '0;
            check("rst_hold_valid", 32'(valid_out), 0);
            check("rst_hold_data", 32'(data_out), 0);
        end else begin
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                check("missing_pulse", 0, 1);
                void'(exp_q.pop_front());
            end
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, e.due);
                    check("pulse_data", 32'(data_out), 32'(e.data));
                end
                last_out = data_out;
                obs_seq.push_back(data_out);
            end else begin
                check("data_hold", 32'(data_out), 32'(last_out));
            end
        end
    end

    task automatic drive(input logic v, input logic b);
        @(posedge clk);
        #1;
        valid_in = v;
        bit_in   = b;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        valid_in = 1'b0;
        #1;
        check("rst_data", 32'(data_out), 0);
        check("rst_valid", 32'(valid_out), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs_seq.delete();
    endtask

    // mode: 0 const 1, 1 const 0, 2 alternating, 3 random
    task automatic feed(input int mode, input int nbits, input bit gapped);
        logic b;
        for (int i = 0; i < nbits; i++) begin
            case (mode)
                0:       b = 1'b1;
                1:       b = 1'b0;
                2:       b = (i % 2 == 0);
                default: b = 1'($urandom % 2);
            endcase
            drive(1'b1, b);
            if (gapped) repeat ($urandom_range(1, 3)) drive(1'b0, 1'($urandom % 2));
        end
        drive(1'b0, 1'b0);
    endtask

    task automatic drain();
        repeat (ORDER + 6) drive(1'b0, 1'b0);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst      = 1'b1;
        valid_in = 1'b0;
        bit_in   = 1'b0;
        repeat (3) @(posedge clk);
        do_reset();

        // Constant +1 at full rate
        feed(0, DEC * 6, 1'b0);
        drain();
        check("t1_count", obs_seq.size(), 6);
        check("t1_dc", 32'(obs_seq[obs_seq.size()-1]), 32'h4000);
        t1_seq = obs_seq;

        // Constant -1
        do_reset();
        feed(1, DEC * 6, 1'b0);
        drain();
        check("t2_dc", 32'(obs_seq[obs_seq.size()-1]), 32'hC000);

        // Alternating bits
        do_reset();
        feed(2, DEC * 6, 1'b0);
        drain();
        check("t3_dc", 32'(obs_seq[obs_seq.size()-1]), 32'h0000);

        // Constant +1 with random idle gaps
        do_reset();
        feed(0, DEC * 6, 1'b1);
        drain();
        check("t5_count", obs_seq.size(), 6);
        for (int i = 0; i < 6 && i < obs_seq.size(); i++)
            check("t5_seq", 32'(obs_seq[i]), 32'(t1_seq[i]));

        // Reset while a comb strobe is in flight, then repeat the constant +1 run
        do_reset();
        for (int i = 0; i < DEC * 2 + 2; i++) drive(1'b1, 1'b1);
        do_reset();
        drain();
        check("t6_no_pulse", obs_seq.size(), 0);
        feed(0, DEC * 6, 1'b0);
        drain();
        check("t6_count", obs_seq.size(), 6);
        for (int i = 0; i < 6 && i < obs_seq.size(); i++)
            check("t6_seq", 32'(obs_seq[i]), 32'(t1_seq[i]));

        // Random bitstream, full rate then gapped
        do_reset();
        feed(3, 20000, 1'b0);
        drain();
        feed(3, 3000, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
